// File: rtl/vga_draw_pkg.sv
// Shared types for the VGA drawing engine: coordinates, deltas, FSM states.
// Default screen geometry and a small signed helper live here too.
package vga_draw_pkg;

  localparam int WIDTH_DEF  = 640;
  localparam int HEIGHT_DEF = 480;

  typedef logic [9:0]         xcoord_t;
  typedef logic [8:0]         ycoord_t;
  typedef logic signed [11:0] delta_t;

  typedef enum logic [2:0] {
    IDLE,
    LINE_INIT,
    LINE_DRAW,
    CLEAR,
    FINISH
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
    ,WAIT_FRAME
`endif
  } plot_state_t;

  function automatic delta_t abs_diff(delta_t a, delta_t b);
    delta_t d;
    d = a - b;
    return d[11] ? -d : d;
  endfunction

endpackage

// File: rtl/vga_line_plotter_line_step_core.sv
// Combinational Bresenham step: next error term and next point.
// Ports: err/dx/dy, step directions, current and end point in; next err/point, at_end out.
module line_step_core
  import vga_draw_pkg::*;
(
  input  delta_t  i_err,
  input  delta_t  i_dx,
  input  delta_t  i_dy,
  input  logic    i_sx_neg,
  input  logic    i_sy_neg,
  input  xcoord_t i_x,
  input  ycoord_t i_y,
  input  xcoord_t i_x_end,
  input  ycoord_t i_y_end,
  output delta_t  o_err,
  output xcoord_t o_x,
  output ycoord_t o_y,
  output logic    o_at_end
);

  logic signed [12:0] w_e2;
  logic signed [12:0] w_dx13;
  logic signed [12:0] w_dy13;
  logic               w_step_x;
  logic               w_step_y;

  assign w_e2     = {i_err, 1'b0};
  assign w_dx13   = i_dx;
  assign w_dy13   = i_dy;
  assign w_step_x = (w_e2 >= w_dy13);
  assign w_step_y = (w_e2 <= w_dx13);
  assign o_at_end = (i_x == i_x_end) && (i_y == i_y_end);

  always_comb begin
    o_err = i_err;
    o_x   = i_x;
    o_y   = i_y;
    if (w_step_x) begin
      o_err = o_err + i_dy;
      o_x   = i_sx_neg ? i_x - 10'd1 : i_x + 10'd1;
    end
    if (w_step_y) begin
      o_err = o_err + i_dx;
      o_y   = i_sy_neg ? i_y - 9'd1 : i_y + 9'd1;
    end
  end

endmodule

// File: rtl/vga_line_plotter.sv
// Line / clear drawing engine feeding a framebuffer write port, one pixel per clock.
// Ports: start/clear commands, line operands and colours in; busy, done, x/y/pixel_color/pixel_write out.
// Optional VGA_LINE_PLOTTER_FRAME_SYNC_EN: accepted commands wait for the next frame_start.
module vga_line_plotter
  import vga_draw_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  logic    clear,
  input  xcoord_t x0,
  input  ycoord_t y0,
  input  xcoord_t x1,
  input  ycoord_t y1,
  input  logic    color,
  input  logic    clear_color,
  input  logic    frame_start,
  output logic    busy,
  output logic    done,
  output xcoord_t x,
  output ycoord_t y,
  output logic    pixel_color,
  output logic    pixel_write
);

  localparam xcoord_t XLAST = xcoord_t'(WIDTH - 1);
  localparam ycoord_t YLAST = ycoord_t'(HEIGHT - 1);

  plot_state_t r_state;
  xcoord_t     r_cx;
  ycoord_t     r_cy;
  xcoord_t     r_x1;
  ycoord_t     r_y1;
  logic        r_col;
  delta_t      r_dx;
  delta_t      r_dy;
  delta_t      r_err;
  logic        r_sxn;
  logic        r_syn;
  logic        r_busy;
  logic        r_done;
  xcoord_t     r_x;
  ycoord_t     r_y;
  logic        r_pc;
  logic        r_pw;
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
  logic        r_is_clear;
`endif

  delta_t  w_dx;
  delta_t  w_dy;
  delta_t  w_nerr;
  xcoord_t w_nx;
  ycoord_t w_ny;
  logic    w_at_end;
  xcoord_t w_clr_nx;
  ycoord_t w_clr_ny;
  logic    w_clr_last;

  function automatic logic on_screen(xcoord_t px, ycoord_t py);
    return (px <= XLAST) && (py <= YLAST);
  endfunction

  assign w_dx = abs_diff($signed({2'b00, r_x1}), $signed({2'b00, r_cx}));
  assign w_dy = -abs_diff($signed({3'b000, r_y1}), $signed({3'b000, r_cy}));

  line_step_core u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sxn),
    .i_sy_neg (r_syn),
    .i_x      (r_cx),
    .i_y      (r_cy),
    .i_x_end  (r_x1),
    .i_y_end  (r_y1),
    .o_err    (w_nerr),
    .o_x      (w_nx),
    .o_y      (w_ny),
    .o_at_end (w_at_end)
  );

  // Raster cursor for the clear fill: x wraps at the last column.
  assign w_clr_last = (r_cx == XLAST) && (r_cy == YLAST);

  always_comb begin
    w_clr_nx = r_cx + 10'd1;
    w_clr_ny = r_cy;
    if (r_cx == XLAST) begin
      w_clr_nx = '0;
      w_clr_ny = r_cy + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_col   <= 1'b0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_err   <= '0;
      r_sxn   <= 1'b0;
      r_syn   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_pc    <= 1'b0;
      r_pw    <= 1'b0;
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
      r_is_clear <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pw   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (clear) begin
            r_busy <= 1'b1;
            r_col  <= clear_color;
            r_cx   <= '0;
            r_cy   <= '0;
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
            r_is_clear <= 1'b1;
            r_state    <= WAIT_FRAME;
`else
            // First fill pixel is presented as the command is accepted.
            r_x     <= '0;
            r_y     <= '0;
            r_pc    <= clear_color;
            r_pw    <= 1'b1;
            r_state <= CLEAR;
`endif
          end else if (start) begin
            r_busy  <= 1'b1;
            r_col   <= color;
            r_cx    <= x0;
            r_cy    <= y0;
            r_x1    <= x1;
            r_y1    <= y1;
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
            r_is_clear <= 1'b0;
            r_state    <= WAIT_FRAME;
`else
            r_state <= LINE_INIT;
`endif
          end
        end
`ifdef VGA_LINE_PLOTTER_FRAME_SYNC_EN
        WAIT_FRAME: begin
          if (frame_start) begin
            if (r_is_clear) begin
              r_x     <= '0;
              r_y     <= '0;
              r_pc    <= r_col;
              r_pw    <= 1'b1;
              r_state <= CLEAR;
            end else begin
              r_state <= LINE_INIT;
            end
          end
        end
`endif
        LINE_INIT: begin
          // Setup and the first point are registered together.
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_err   <= w_dx + w_dy;
          r_sxn   <= !(r_cx < r_x1);
          r_syn   <= !(r_cy < r_y1);
          r_x     <= r_cx;
          r_y     <= r_cy;
          r_pc    <= r_col;
          r_pw    <= on_screen(r_cx, r_cy);
          r_state <= LINE_DRAW;
        end
        LINE_DRAW: begin
          // The point on the outputs now is the cursor; stop once it is the end.
          if (w_at_end) begin
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_err <= w_nerr;
            r_cx  <= w_nx;
            r_cy  <= w_ny;
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_pc  <= r_col;
            r_pw  <= on_screen(w_nx, w_ny);
          end
        end
        CLEAR: begin
          if (w_clr_last) begin
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_cx <= w_clr_nx;
            r_cy <= w_clr_ny;
            r_x  <= w_clr_nx;
            r_y  <= w_clr_ny;
            r_pc <= r_col;
            r_pw <= 1'b1;
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign x           = r_x;
  assign y           = r_y;
  assign pixel_color = r_pc;
  assign pixel_write = r_pw;

`ifndef VGA_LINE_PLOTTER_FRAME_SYNC_EN
  logic w_unused;
  assign w_unused = frame_start;
`endif

endmodule

// File: tb/tb_vga_line_plotter.sv
// Scoreboard bench for vga_line_plotter: directed plus random lines, clear, reset.
// Expected writes carry the cycle they must appear in; a negedge monitor pops them.
module tb_vga_line_plotter;

  localparam int W = 640;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] x0 = '0;
  logic [8:0] y0 = '0;
  logic [9:0] x1 = '0;
  logic [8:0] y1 = '0;
  logic       color = 1'b0;
  logic       clear_color = 1'b0;
  logic       frame_start = 1'b0;
  logic       busy;
  logic       done;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_color;
  logic       pixel_write;

  vga_line_plotter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .color       (color),
    .clear_color (clear_color),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .x           (x),
    .y           (y),
    .pixel_color (pixel_color),
    .pixel_write (pixel_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_done;
    int px;
    int py;
    bit c;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ev(bit d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s at cycle %0d: got (%0d,%0d) expected nothing",
               d ? "done" : "write", cyc, x, y);
    end else begin
      e = q.pop_front();
      if (e.is_done != d || e.cyc != cyc ||
          (!d && (e.px != int'(x) || e.py != int'(y) || e.c != pixel_color))) begin
        errors++;
        $display("FAIL event: got done=%0d cyc=%0d (%0d,%0d) c=%0d expected done=%0d cyc=%0d (%0d,%0d) c=%0d",
                 d, cyc, x, y, pixel_color, e.is_done, e.cyc, e.px, e.py, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_write) check_ev(1'b0);
      if (done) check_ev(1'b1);
    end
  end

  // Reference: first point 2 cycles after the start cycle, one point per cycle,
  // off-screen points use their cycle but are not written, done right after.
  task automatic model_line(int n, int ax, int ay, int bx, int by, bit c,
                            output int done_cyc);
    int dx, dy, sx, sy, err, e2, px, py, k;
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = (by > ay) ? ay - by : by - ay;
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx + dy;
    px  = ax;
    py  = ay;
    k   = 0;
    forever begin
      if (px < W && py < H) q.push_back('{n + 2 + k, 1'b0, px, py, c});
      if (px == bx && py == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
      k++;
    end
    done_cyc = n + 3 + k;
    q.push_back('{done_cyc, 1'b1, 0, 0, 1'b0});
  endtask

  task automatic model_clear(int n, bit c, output int done_cyc);
    for (int i = 0; i < W * H; i++)
      q.push_back('{n + 1 + i, 1'b0, i % W, i / W, c});
    done_cyc = n + 1 + W * H;
    q.push_back('{done_cyc, 1'b1, 0, 0, 1'b0});
  endtask

  task automatic issue_line(int ax, int ay, int bx, int by, bit c,
                            output int done_cyc);
    @(posedge clk); #1;
    x0 = 10'(ax); y0 = 9'(ay); x1 = 10'(bx); y1 = 9'(by); color = c;
    start = 1'b1;
    model_line(cyc, ax, ay, bx, by, c, done_cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(int done_cyc, string nm);
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, cyc, done_cyc + 1);
  endtask

  int dc;
  int ax, ay, bx, by;

  initial begin
    #12;
    chk("reset_pixel_write", pixel_write, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_color", pixel_color, 0);
    #5 rst = 1'b0;

    issue_line(0, 0, 3, 0, 1'b1, dc);
    wait_idle(dc, "horiz_busy_fall");
    issue_line(5, 5, 7, 10, 1'b1, dc);
    wait_idle(dc, "steep_busy_fall");
    issue_line(10, 2, 7, 2, 1'b0, dc);
    wait_idle(dc, "reverse_busy_fall");
    issue_line(4, 4, 4, 4, 1'b1, dc);
    wait_idle(dc, "point_busy_fall");
    issue_line(638, 0, 641, 0, 1'b1, dc);
    wait_idle(dc, "clip_busy_fall");
    issue_line(630, 30, 645, 34, 1'b1, dc);
    wait_idle(dc, "clip_y_busy_fall");

    // Commands arriving while busy must be dropped.
    issue_line(20, 1, 70, 9, 1'b1, dc);
    repeat (5) @(posedge clk);
    #1;
    x0 = 10'd1; y0 = 9'd1; x1 = 10'd2; y1 = 9'd2;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    wait_idle(dc, "busy_ignore_fall");

    // Clear and start together: only the fill happens.
    @(posedge clk); #1;
    x0 = 10'd3; y0 = 9'd3; x1 = 10'd9; y1 = 9'd9; color = 1'b1;
    start = 1'b1; clear = 1'b1; clear_color = 1'b0;
    model_clear(cyc, 1'b0, dc);
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    wait_idle(dc, "clear_busy_fall");

    // Reset mid-line: outputs drop at once and no done follows.
    issue_line(0, 0, 100, 0, 1'b1, dc);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset_pixel_write", pixel_write, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_x", x, 0);
    chk("midreset_done", done, 0);
    q.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    issue_line(2, 3, 9, 5, 1'b1, dc);
    wait_idle(dc, "post_reset_busy_fall");

    for (int i = 0; i < 25; i++) begin
      ax = $urandom_range(0, 700);
      bx = $urandom_range(0, 700);
      ay = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40);
      by = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40);
      issue_line(ax, ay, bx, by, 1'($urandom_range(0, 1)), dc);
      wait_idle(dc, "rand_busy_fall");
    end

    repeat (3) @(posedge clk);
    chk("leftover_expected", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
